stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
- Push/pop sequencer that drives the existing stack pointer through its 2-bit sp_select interface and performs the matching data-memory accesses.
- Sits between the CPU execute stage and the data-memory port.
- Accepts push and pop requests, keeps SP and memory in lockstep (SP = next free slot, post-increment push, pre-decrement pop), and reports overflow, underflow and protocol errors.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, address width (matches sp_addr)
- STACK_DEPTH, 256, maximum number of stacked words
- TIMEOUT_CYCLES, 16, mem_ack wait limit; used only with STACK_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low; shared with the SP block
- push_req  in  1  push request, sampled only when busy=0
- pop_req  in  1  pop request, sampled only when busy=0
- push_data  in  DATA_W  word to push, captured on accept
- busy  out  1  high in any state other than IDLE
- push_done  out  1  one-cycle pulse when a push completes
- pop_valid  out  1  one-cycle pulse qualifying pop_data
- pop_data  out  DATA_W  popped word, held until the next pop
- err_code  out  3  sticky error code
- err_clr  in  1  clears err_code to 000
- depth  out  $clog2(STACK_DEPTH+1)  current stacked word count
- sp_select  out  2  to SP: 00 hold, 01 inc, 10 dec (11 never driven)
- sp_addr  in  ADDR_W  from SP, current pointer
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  equals sp_addr while mem_req is high, 0 otherwise
- mem_wdata  out  DATA_W  captured push_data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  access complete; may arrive in the same cycle as mem_req

Behaviour:
- Reset: state IDLE. All outputs and registers clear to 0: busy, push_done, pop_valid, pop_data, err_code, depth, sp_select, mem_req, mem_we, mem_wdata.
- Reset mid-operation aborts immediately. No further SP or memory activity; the SP resets on the same rst_n.
- States: IDLE, PUSH_WR, PUSH_INC, POP_DEC, POP_WAIT, POP_RD.
- IDLE, accept rules:
  - push_req only and depth<STACK_DEPTH: capture push_data, go to PUSH_WR.
  - push_req only and depth==STACK_DEPTH: err_code<=001 (overflow), stay IDLE.
  - pop_req only and depth>0: go to POP_DEC.
  - pop_req only and depth==0: err_code<=010 (underflow), stay IDLE.
  - push_req and pop_req together: err_code<=011 (collision), neither operation is performed.
- PUSH_WR: mem_req=1, mem_we=1. On mem_ack go to PUSH_INC.
- PUSH_INC: sp_select=01, depth+1, push_done=1, go to IDLE.
- POP_DEC: sp_select=10, depth-1, go to POP_WAIT.
- POP_WAIT: one cycle so the SP's registered sp_addr settles.
- POP_RD: mem_req=1, mem_we=0. On mem_ack, pop_data<=mem_rdata and go to IDLE; pop_valid=1 in the first IDLE cycle.
- Latency with a same-cycle ack:
  - Push: accept at cycle 0, push_done at cycle 2, busy low at cycle 3.
  - Pop: accept at cycle 0, pop_valid at cycle 4.
- A new request is accepted in the cycle pop_valid is high.
- sp_select is 00 in every state other than PUSH_INC and POP_DEC.
- err_code:
  - Sticky; a later error overwrites the earlier one.
  - err_clr has priority over a same-cycle error set.
  - Errors never change depth or the SP.

Optional Feature:
- STACK_TIMEOUT_EN defined: a counter runs while mem_req is high.
  - After TIMEOUT_CYCLES cycles without mem_ack: drop mem_req, err_code<=100, go to IDLE.
  - No SP update on the aborted push (PUSH_INC is skipped).
  - For an aborted pop, the decrement already issued stands.
- Undefined: waits for mem_ack indefinitely; code 100 never produced.

Decomposition:
- stack_pkg holds:
  - state enum
  - sp_select constants SP_HOLD=2'b00, SP_INC=2'b01, SP_DEC=2'b10, SP_BAD=2'b11
  - err codes ERR_NONE, ERR_OVF, ERR_UNF, ERR_COLL, ERR_TMO
  - STACK_BASE=32'h2000
- One sub-module, stack_ack_timer (timeout counter), instantiated only under STACK_TIMEOUT_EN.
- SP is instantiated alongside by the integrator, not inside.

Test Plan:
- Reset, push 0xDEADBEEF with ack same cycle -> mem write addr 0x2000, sp_select=01 one cycle, push_done at cycle 2, depth=1, SP=0x2001.
- Push 0x11, 0x22, then pop twice, ack delayed 3 cycles -> reads at 0x2001 then 0x2000, pop_data 0x22 then 0x11, depth=0, SP=0x2000.
- Pop at depth 0 -> err_code=010, no mem_req, sp_select stays 00; err_clr -> 000.
- STACK_DEPTH=4: five pushes -> fifth gives err_code=001, depth=4, SP=0x2004; push_req+pop_req together -> err_code=011, no activity.
- Assert rst_n low during PUSH_WR -> mem_req drops asynchronously, depth=0, busy=0, SP=0x2000.
- STACK_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack withheld on a push -> mem_req drops after 16 cycles, err_code=100, SP unchanged.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and constants for the stack push/pop sequencer.
package stack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH_WR  = 3'd1,
        ST_PUSH_INC = 3'd2,
        ST_POP_DEC  = 3'd3,
        ST_POP_WAIT = 3'd4,
        ST_POP_RD   = 3'd5
    } state_t;

    localparam logic [1:0] SP_HOLD = 2'b00;
    localparam logic [1:0] SP_INC  = 2'b01;
    localparam logic [1:0] SP_DEC  = 2'b10;
    localparam logic [1:0] SP_BAD  = 2'b11;

    localparam logic [2:0] ERR_NONE = 3'b000;
    localparam logic [2:0] ERR_OVF  = 3'b001;
    localparam logic [2:0] ERR_UNF  = 3'b010;
    localparam logic [2:0] ERR_COLL = 3'b011;
    localparam logic [2:0] ERR_TMO  = 3'b100;

    localparam logic [31:0] STACK_BASE = 32'h2000;

endpackage

// File: rtl/stack_ack_timer.sv
// mem_ack wait timer: a down-counter reloaded whenever no access is pending.
// expired is high on the TIMEOUT_CYCLES-th consecutive cycle of run.
module stack_ack_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expired
);
    import stack_pkg::*;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Reload while idle, count down while waiting, park at terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = run && (cnt_q == '0);

endmodule

// File: rtl/stack_ctrl.sv
// Push/pop sequencer keeping an external stack pointer and data memory in
// lockstep (post-increment push, pre-decrement pop). All outputs registered
// except mem_addr, which forwards sp_addr while a request is outstanding.
// Optional: define STACK_TIMEOUT_EN to abort accesses whose mem_ack never comes.
//
// state       | meaning
// ST_IDLE     | waiting for push_req / pop_req, flags errors
// ST_PUSH_WR  | memory write at current SP, waiting for mem_ack
// ST_PUSH_INC | SP increment, push_done pulse
// ST_POP_DEC  | SP decrement
// ST_POP_WAIT | let the SP's registered sp_addr settle
// ST_POP_RD   | memory read at decremented SP, waiting for mem_ack
module stack_ctrl #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned STACK_DEPTH    = 256,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push_req,
    input  logic                               pop_req,
    input  logic [DATA_W-1:0]                  push_data,
    output logic                               busy,
    output logic                               push_done,
    output logic                               pop_valid,
    output logic [DATA_W-1:0]                  pop_data,
    output logic [2:0]                         err_code,
    input  logic                               err_clr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic [1:0]                         sp_select,
    input  logic [ADDR_W-1:0]                  sp_addr,
    output logic                               mem_req,
    output logic                               mem_we,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                  mem_wdata,
    input  logic [DATA_W-1:0]                  mem_rdata,
    input  logic                               mem_ack
);
    import stack_pkg::*;

    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                push_done_q, push_done_d;
    logic                pop_valid_q, pop_valid_d;
    logic [DATA_W-1:0]   pop_data_q, pop_data_d;
    logic [2:0]          err_code_q, err_code_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic [1:0]          sp_select_q, sp_select_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                err_set;
    logic [2:0]          err_val;
    logic                tmo_expired;

`ifdef STACK_TIMEOUT_EN
    stack_ack_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ack_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (mem_req_q && !mem_ack),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    // Next-state and next-output logic; outputs change on the transition
    // into the state they belong to so they are valid for that whole state.
    always_comb begin
        state_d     = state_q;
        push_done_d = 1'b0;
        pop_valid_d = 1'b0;
        pop_data_d  = pop_data_q;
        depth_d     = depth_q;
        sp_select_d = SP_HOLD;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        err_set     = 1'b0;
        err_val     = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                if (push_req && pop_req) begin
                    err_set = 1'b1;
                    err_val = ERR_COLL;
                end else if (push_req) begin
                    if (depth_q == DEPTH_MAX) begin
                        err_set = 1'b1;
                        err_val = ERR_OVF;
                    end else begin
                        mem_wdata_d = push_data;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        state_d     = ST_PUSH_WR;
                    end
                end else if (pop_req) begin
                    if (depth_q == '0) begin
                        err_set = 1'b1;
                        err_val = ERR_UNF;
                    end else begin
                        sp_select_d = SP_DEC;
                        depth_d     = depth_q - DEPTH_W'(1);
                        state_d     = ST_POP_DEC;
                    end
                end
            end
            ST_PUSH_WR: begin
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    sp_select_d = SP_INC;
                    depth_d     = depth_q + DEPTH_W'(1);
                    push_done_d = 1'b1;
                    state_d     = ST_PUSH_INC;
                end else if (tmo_expired) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_set   = 1'b1;
                    err_val   = ERR_TMO;
                    state_d   = ST_IDLE;
                end
            end
            ST_PUSH_INC: begin
                state_d = ST_IDLE;
            end
            ST_POP_DEC: begin
                state_d = ST_POP_WAIT;
            end
            ST_POP_WAIT: begin
                mem_req_d = 1'b1;
                mem_we_d  = 1'b0;
                state_d   = ST_POP_RD;
            end
            ST_POP_RD: begin
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    pop_data_d  = mem_rdata;
                    pop_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (tmo_expired) begin
                    mem_req_d = 1'b0;
                    err_set   = 1'b1;
                    err_val   = ERR_TMO;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);

        err_code_d = err_code_q;
        if (err_clr) begin
            err_code_d = ERR_NONE;
        end else if (err_set) begin
            err_code_d = err_val;
        end
    end

    // State and registered outputs; async reset aborts any access at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            push_done_q <= 1'b0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
            err_code_q  <= ERR_NONE;
            depth_q     <= '0;
            sp_select_q <= SP_HOLD;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            push_done_q <= push_done_d;
            pop_valid_q <= pop_valid_d;
            pop_data_q  <= pop_data_d;
            err_code_q  <= err_code_d;
            depth_q     <= depth_d;
            sp_select_q <= sp_select_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign push_done = push_done_q;
    assign pop_valid = pop_valid_q;
    assign pop_data  = pop_data_q;
    assign err_code  = err_code_q;
    assign depth     = depth_q;
    assign sp_select = sp_select_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_req_q ? sp_addr : '0;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural stack pointer and a
// data memory whose ack latency can be set or withheld.
module tb_stack_ctrl;

    localparam logic [31:0] BASE = 32'h2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push_req = 1'b0;
    logic        pop_req = 1'b0;
    logic [31:0] push_data = '0;
    logic        busy, push_done, pop_valid;
    logic [31:0] pop_data;
    logic [2:0]  err_code;
    logic        err_clr = 1'b0;
    logic [2:0]  depth;
    logic [1:0]  sp_select;
    logic [31:0] sp_addr;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    int ack_delay = 0;
    bit withhold = 1'b0;
    int wait_cnt = 0;
    int activity = 0;
    int bad_sel = 0;
    int pd_cnt = 0;
    logic [31:0] sp_q;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] mem_arr [0:15];

    always #5 clk = ~clk;

    stack_ctrl #(
        .DATA_W(32), .ADDR_W(32), .STACK_DEPTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .push_req(push_req), .pop_req(pop_req),
        .push_data(push_data), .busy(busy), .push_done(push_done),
        .pop_valid(pop_valid), .pop_data(pop_data), .err_code(err_code),
        .err_clr(err_clr), .depth(depth), .sp_select(sp_select),
        .sp_addr(sp_addr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    // Stack pointer block shared with the integrator, reset on the same rst_n.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sp_q <= BASE;
        else if (sp_select == 2'b01) sp_q <= sp_q + 1;
        else if (sp_select == 2'b10) sp_q <= sp_q - 1;
    end
    assign sp_addr = sp_q;

    // Memory responder and activity monitors.
    assign mem_ack   = mem_req && !withhold && (wait_cnt >= ack_delay);
    assign mem_rdata = mem_arr[mem_addr[3:0]];

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                mem_arr[mem_addr[3:0]] <= mem_wdata;
                last_wr_addr <= mem_addr;
            end else begin
                last_rd_addr <= mem_addr;
            end
        end
        if (mem_req || sp_select != 2'b00) activity <= activity + 1;
        if (sp_select == 2'b11) bad_sel <= bad_sel + 1;
        if (push_done) pd_cnt <= pd_cnt + 1;
    end

    task automatic apply_reset;
        rst_n = 1'b0; push_req = 1'b0; pop_req = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_op(input logic [31:0] d, output bit ok);
        ok = 1'b0;
        @(negedge clk); push_data = d; push_req = 1'b1;
        @(negedge clk); push_req = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (push_done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic pop_op(output logic [31:0] d, output bit ok);
        ok = 1'b0; d = '0;
        @(negedge clk); pop_req = 1'b1;
        @(negedge clk); pop_req = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (pop_valid) begin ok = 1'b1; d = pop_data; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        apply_reset();
        checks++;
        if ({busy, push_done, pop_valid, sp_select, mem_req, mem_we} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {busy, push_done, pop_valid, sp_select, mem_req, mem_we});
        end
        checks++;
        if ({pop_data, mem_wdata, mem_addr} !== 96'h0) begin
            failures++; $display("FAIL reset_data got=%h %h %h exp=0", pop_data, mem_wdata, mem_addr);
        end
        checks++;
        if ({err_code, depth} !== 6'b0) begin
            failures++; $display("FAIL reset_err_depth got=%b %b exp=0", err_code, depth);
        end
    endtask

    task automatic test_push_same_cycle;
        ack_delay = 0; withhold = 1'b0;
        @(negedge clk); push_data = 32'hDEADBEEF; push_req = 1'b1;
        @(negedge clk); push_req = 1'b0;
        checks++;
        if ({busy, mem_req, mem_we, push_done} !== 4'b1110) begin
            failures++; $display("FAIL push_c1_ctrl got=%b exp=1110", {busy, mem_req, mem_we, push_done});
        end
        checks++;
        if (mem_addr !== BASE || mem_wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL push_c1_addr got=%h/%h exp=%h/deadbeef", mem_addr, mem_wdata, BASE);
        end
        @(negedge clk);
        checks++;
        if ({push_done, sp_select, mem_req} !== 4'b1010 || depth !== 3'd1) begin
            failures++; $display("FAIL push_c2 got=%b depth=%0d exp=1010 depth=1", {push_done, sp_select, mem_req}, depth);
        end
        checks++;
        if (last_wr_addr !== BASE || mem_arr[0] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL push_mem got=%h@%h exp=deadbeef@%h", mem_arr[0], last_wr_addr, BASE);
        end
        @(negedge clk);
        checks++;
        if ({busy, push_done, sp_select} !== 4'b0 || sp_q !== BASE + 1) begin
            failures++; $display("FAIL push_c3 got=%b sp=%h exp=0000 sp=%h", {busy, push_done, sp_select}, sp_q, BASE + 1);
        end
        // Pop latency with same-cycle ack.
        @(negedge clk); pop_req = 1'b1;
        @(negedge clk); pop_req = 1'b0;
        checks++;
        if (sp_select !== 2'b10 || depth !== 3'd0 || busy !== 1'b1) begin
            failures++; $display("FAIL pop_c1 got=sel%b depth%0d busy%b exp=sel10 depth0 busy1", sp_select, depth, busy);
        end
        @(negedge clk);
        checks++;
        if (sp_select !== 2'b00 || mem_req !== 1'b0 || sp_q !== BASE) begin
            failures++; $display("FAIL pop_c2 got=sel%b req%b sp%h exp=sel00 req0 sp%h", sp_select, mem_req, sp_q, BASE);
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== BASE) begin
            failures++; $display("FAIL pop_c3 got=req%b we%b addr%h exp=req1 we0 addr%h", mem_req, mem_we, mem_addr, BASE);
        end
        @(negedge clk);
        checks++;
        if (pop_valid !== 1'b1 || pop_data !== 32'hDEADBEEF || busy !== 1'b0) begin
            failures++; $display("FAIL pop_c4 got=v%b d%h busy%b exp=v1 ddeadbeef busy0", pop_valid, pop_data, busy);
        end
        @(negedge clk);
        checks++;
        if (pop_valid !== 1'b0 || pop_data !== 32'hDEADBEEF) begin
            failures++; $display("FAIL pop_hold got=v%b d%h exp=v0 ddeadbeef", pop_valid, pop_data);
        end
    endtask

    task automatic test_push_pop_delayed;
        bit ok;
        logic [31:0] d;
        apply_reset();
        ack_delay = 3; withhold = 1'b0;
        push_op(32'h11, ok);
        checks++; if (!ok) begin failures++; $display("FAIL dly_push1 got=timeout exp=push_done"); end
        push_op(32'h22, ok);
        checks++; if (!ok) begin failures++; $display("FAIL dly_push2 got=timeout exp=push_done"); end
        checks++;
        if (depth !== 3'd2 || sp_q !== BASE + 2) begin
            failures++; $display("FAIL dly_depth2 got=%0d sp%h exp=2 sp%h", depth, sp_q, BASE + 2);
        end
        pop_op(d, ok);
        checks++;
        if (!ok || d !== 32'h22 || last_rd_addr !== BASE + 1) begin
            failures++; $display("FAIL dly_pop1 got=ok%b d%h a%h exp=ok1 d22 a%h", ok, d, last_rd_addr, BASE + 1);
        end
        pop_op(d, ok);
        checks++;
        if (!ok || d !== 32'h11 || last_rd_addr !== BASE) begin
            failures++; $display("FAIL dly_pop2 got=ok%b d%h a%h exp=ok1 d11 a%h", ok, d, last_rd_addr, BASE);
        end
        @(negedge clk);
        checks++;
        if (depth !== 3'd0 || sp_q !== BASE || err_code !== 3'b000) begin
            failures++; $display("FAIL dly_final got=d%0d sp%h e%b exp=d0 sp%h e000", depth, sp_q, err_code, BASE);
        end
    endtask

    task automatic test_underflow;
        int act0;
        act0 = activity;
        @(negedge clk); pop_req = 1'b1;
        @(negedge clk); pop_req = 1'b0;
        checks++;
        if (err_code !== 3'b010 || busy !== 1'b0) begin
            failures++; $display("FAIL unf_err got=%b busy%b exp=010 busy0", err_code, busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (activity !== act0 || sp_q !== BASE) begin
            failures++; $display("FAIL unf_quiet got=act%0d sp%h exp=act%0d sp%h", activity, sp_q, act0, BASE);
        end
        err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        checks++;
        if (err_code !== 3'b000) begin
            failures++; $display("FAIL unf_clr got=%b exp=000", err_code);
        end
        err_clr = 1'b1; pop_req = 1'b1;
        @(negedge clk); err_clr = 1'b0; pop_req = 1'b0;
        checks++;
        if (err_code !== 3'b000 || busy !== 1'b0) begin
            failures++; $display("FAIL clr_priority got=%b busy%b exp=000 busy0", err_code, busy);
        end
    endtask

    task automatic test_overflow_collision;
        bit ok;
        int act0;
        apply_reset();
        ack_delay = 0; withhold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_op(32'hA0 + i, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL ovf_push%0d got=timeout exp=push_done", i); end
        end
        checks++;
        if (depth !== 3'd4 || sp_q !== BASE + 4 || mem_arr[3] !== 32'hA3) begin
            failures++; $display("FAIL ovf_full got=d%0d sp%h m%h exp=d4 sp%h ma3", depth, sp_q, mem_arr[3], BASE + 4);
        end
        act0 = activity;
        @(negedge clk); push_data = 32'hBAD; push_req = 1'b1;
        @(negedge clk); push_req = 1'b0;
        checks++;
        if (err_code !== 3'b001 || busy !== 1'b0) begin
            failures++; $display("FAIL ovf_err got=%b busy%b exp=001 busy0", err_code, busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (activity !== act0 || depth !== 3'd4 || sp_q !== BASE + 4) begin
            failures++; $display("FAIL ovf_quiet got=act%0d d%0d sp%h exp=act%0d d4 sp%h", activity, depth, sp_q, act0, BASE + 4);
        end
        push_req = 1'b1; pop_req = 1'b1;
        @(negedge clk); push_req = 1'b0; pop_req = 1'b0;
        checks++;
        if (err_code !== 3'b011 || busy !== 1'b0) begin
            failures++; $display("FAIL coll_err got=%b busy%b exp=011 busy0", err_code, busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (activity !== act0 || depth !== 3'd4) begin
            failures++; $display("FAIL coll_quiet got=act%0d d%0d exp=act%0d d4", activity, depth, act0);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        apply_reset();
        ack_delay = 0; withhold = 1'b0;
        push_op(32'h55, ok);
        checks++; if (!ok || depth !== 3'd1) begin failures++; $display("FAIL rm_setup got=ok%b d%0d exp=ok1 d1", ok, depth); end
        withhold = 1'b1;
        @(negedge clk); push_data = 32'h66; push_req = 1'b1;
        @(negedge clk); push_req = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL rm_in_wr got=req%b busy%b exp=req1 busy1", mem_req, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || depth !== 3'd0 || sp_q !== BASE) begin
            failures++; $display("FAIL rm_abort got=req%b busy%b d%0d sp%h exp=req0 busy0 d0 sp%h", mem_req, busy, depth, sp_q, BASE);
        end
        @(negedge clk); rst_n = 1'b1; withhold = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || sp_q !== BASE) begin
            failures++; $display("FAIL rm_after got=req%b busy%b sp%h exp=req0 busy0 sp%h", mem_req, busy, sp_q, BASE);
        end
    endtask

    task automatic test_timeout;
        int hi;
        int pd0;
        apply_reset();
        withhold = 1'b1;
        pd0 = pd_cnt;
        @(negedge clk); push_data = 32'h77; push_req = 1'b1;
        @(negedge clk); push_req = 1'b0;
        hi = 0;
        for (int n = 0; n < 40; n++) begin
            if (mem_req) hi++;
            else break;
            @(negedge clk);
        end
`ifdef STACK_TIMEOUT_EN
        checks++;
        if (hi !== 16) begin failures++; $display("FAIL tmo_len got=%0d exp=16", hi); end
        checks++;
        if (err_code !== 3'b100 || busy !== 1'b0) begin
            failures++; $display("FAIL tmo_err got=%b busy%b exp=100 busy0", err_code, busy);
        end
        checks++;
        if (sp_q !== BASE || depth !== 3'd0 || pd_cnt !== pd0) begin
            failures++; $display("FAIL tmo_sp got=sp%h d%0d pd%0d exp=sp%h d0 pd%0d", sp_q, depth, pd_cnt, BASE, pd0);
        end
`else
        checks++;
        if (hi !== 40 || mem_req !== 1'b1) begin
            failures++; $display("FAIL notmo_wait got=%0d req%b exp=40 req1", hi, mem_req);
        end
        checks++;
        if (err_code !== 3'b000 || pd_cnt !== pd0) begin
            failures++; $display("FAIL notmo_err got=%b pd%0d exp=000 pd%0d", err_code, pd_cnt, pd0);
        end
`endif
        withhold = 1'b0;
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_push_same_cycle();
        test_push_pop_delayed();
        test_underflow();
        test_overflow_collision();
        test_reset_mid();
        test_timeout();
        checks++;
        if (bad_sel !== 0) begin failures++; $display("FAIL sp_select_11 got=%0d exp=0", bad_sel); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=hang exp=finish");
        $fatal(1, "bench timeout");
    end

endmodule
